// File: rtl/instruction_fetch_buffer.sv
// rtl/instruction_fetch_buffer.sv - sequential fetch stage with {pc, instr} queue toward decode; FETCH_C_EXT_EN enables 16-bit fetch
`ifndef XLEN
`define XLEN 32
`endif

module instruction_fetch_buffer #(
  parameter int              XLEN         = `XLEN,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_is_compressed
);

  localparam int            PW         = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;

  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [DEPTH-1:0] isc_mem_q;

  logic             is_c;
  logic [XLEN-1:0]  pc_step;
  logic [XLEN-1:0]  redirect_target;
  logic [XLEN-1:0]  reset_pc;
  logic             pop;
  logic             push;

`ifdef FETCH_C_EXT_EN
  // Variable-length fetch: anything not ending in 2'b11 is a 16-bit instruction.
  assign is_c            = (imem_instruction[1:0] != 2'b11);
  assign redirect_target = redirect_pc & ~XLEN'(1);
  assign reset_pc        = RESET_VECTOR & ~XLEN'(1);
`else
  // Fixed 32-bit fetch: every PC is kept word-aligned.
  assign is_c            = 1'b0;
  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign reset_pc        = RESET_VECTOR & ~XLEN'(3);
`endif

  assign pc_step = is_c ? XLEN'(2) : XLEN'(4);

  // A full queue can still take a fetch in the cycle decode drains its head.
  assign pop  = out_valid & out_ready;
  assign push = !redirect_valid & ((count_q != FULL_COUNT) | pop);

  assign imem_addr         = fetch_pc_q;
  assign out_valid         = (count_q != '0);
  assign out_pc            = pc_mem_q[rd_ptr_q];
  assign out_instr         = instr_mem_q[rd_ptr_q];
  assign out_is_compressed = isc_mem_q[rd_ptr_q];

  // Next-state: redirect flushes and restarts, otherwise push/pop bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + pc_step;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Control state; reset overrides redirect and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= reset_pc;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instruction;
      isc_mem_q[wr_ptr_q]   <= is_c;
    end
  end

endmodule
